// File: rtl/sdram_pixel_fifo_if.sv
// rtl/sdram_pixel_fifo_if.sv - SDRAM read-data capture and pixel-stream handshake bundle
// slave is the FIFO side; master is the controller/consumer environment.
interface sdram_pixel_fifo_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              clear;
  logic [DATA_W-1:0] mem_dq_in;
  logic              data_available;
  logic              pause;
  logic              unpause;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [ADDR_W:0]   fill_level;
  logic              overflow;

  modport slave (
    input  clear, mem_dq_in, data_available, pix_ready,
    output pause, unpause, pix_data, pix_valid, fill_level, overflow
  );

  modport master (
    output clear, mem_dq_in, data_available, pix_ready,
    input  pause, unpause, pix_data, pix_valid, fill_level, overflow
  );
endinterface

// File: rtl/sdram_pixel_fifo.sv
// rtl/sdram_pixel_fifo.sv - SDRAM read-data FIFO with first-word fall-through pixel output
// Pause/unpause pulses throttle the read controller around the high/low water marks.
module sdram_pixel_fifo #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int HIGH_WATER = 12,
  parameter int LOW_WATER  = 4
) (
  input  logic            ck143,
  input  logic            reset,
  sdram_pixel_fifo_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] HW_LVL   = (ADDR_W + 1)'(HIGH_WATER);
  localparam logic [ADDR_W:0] LW_LVL   = (ADDR_W + 1)'(LOW_WATER);

  if (HIGH_WATER >= DEPTH - 1) begin : g_hw_chk
    $error("sdram_pixel_fifo: HIGH_WATER must be <= DEPTH-2");
  end
  if (LOW_WATER >= HIGH_WATER) begin : g_lw_chk
    $error("sdram_pixel_fifo: LOW_WATER must be < HIGH_WATER");
  end

  typedef enum logic {RUNNING, PAUSED} flow_t;

  flow_t             state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   fill_q, fill_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              pause_q, pause_d;
  logic              unpause_q, unpause_d;
  logic              overflow_q, overflow_d;
  logic              full, push, pop;

  always_comb begin
    full       = (fill_q == FULL_LVL);
    push       = bus.data_available && !full && !bus.clear;
    pop        = valid_q && bus.pix_ready && !bus.clear;
    wr_ptr_d   = wr_ptr_q + ADDR_W'(push);
    rd_ptr_d   = rd_ptr_q + ADDR_W'(pop);
    fill_d     = fill_q + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
    overflow_d = overflow_q | (bus.data_available & full & ~bus.clear);
    // The new head is the incoming word only when it lands at the head slot.
    data_d     = (push && (wr_ptr_q == rd_ptr_d)) ? bus.mem_dq_in : mem_q[rd_ptr_d];
    valid_d    = (fill_d != '0);
    state_d    = state_q;
    pause_d    = 1'b0;
    unpause_d  = 1'b0;

    if (bus.clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fill_d     = '0;
      data_d     = '0;
      valid_d    = 1'b0;
      overflow_d = 1'b0;
      state_d    = RUNNING;
      unpause_d  = (state_q == PAUSED);
    end else begin
      case (state_q)
        RUNNING: if (fill_d >= HW_LVL) begin
          state_d = PAUSED;
          pause_d = 1'b1;
        end
        PAUSED: if (fill_d <= LW_LVL) begin
          state_d   = RUNNING;
          unpause_d = 1'b1;
        end
        default: state_d = RUNNING;
      endcase
    end
  end

  always_ff @(posedge ck143) begin
    if (push) mem_q[wr_ptr_q] <= bus.mem_dq_in;
  end

  always_ff @(posedge ck143 or posedge reset) begin
    if (reset) begin
      state_q    <= RUNNING;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      pause_q    <= 1'b0;
      unpause_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      pause_q    <= pause_d;
      unpause_q  <= unpause_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.pix_data   = data_q;
  assign bus.pix_valid  = valid_q;
  assign bus.fill_level = fill_q;
  assign bus.pause      = pause_q;
  assign bus.unpause    = unpause_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_sdram_pixel_fifo.sv
// tb/tb_sdram_pixel_fifo.sv - directed self-checking bench for sdram_pixel_fifo
module tb_sdram_pixel_fifo;
  logic ck143 = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_miss = 0;
  int   n_pause = 0;
  int   n_unpause = 0;
  logic [15:0] q[$];

  always #5 ck143 = ~ck143;

  sdram_pixel_fifo_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  sdram_pixel_fifo #(
    .DATA_W(16), .ADDR_W(4), .HIGH_WATER(12), .LOW_WATER(4)
  ) dut (
    .ck143(ck143),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, score the pop against the queue, then check state after the edge.
  task automatic cycle(input logic da, input logic [15:0] din, input logic rdy, input logic clr);
    logic was_full;
    bus.data_available = da;
    bus.mem_dq_in      = din;
    bus.pix_ready      = rdy;
    bus.clear          = clr;
    was_full = (q.size() == 16);
    if (!clr && bus.pix_valid && rdy) begin
      if (q.size() == 0) chk("pop_when_empty", 32'd1, 32'd0);
      else begin
        chk("pop_data", 32'(bus.pix_data), 32'(q[0]));
        void'(q.pop_front());
      end
    end
    if (clr) q.delete();
    else if (da && !was_full) q.push_back(din);
    @(posedge ck143);
    #1;
    n_pause   += int'(bus.pause);
    n_unpause += int'(bus.unpause);
    chk("fill", 32'(bus.fill_level), 32'(q.size()));
    chk("valid", 32'(bus.pix_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("head", 32'(bus.pix_data), 32'(q[0]));
    chk("pulse_excl", 32'(bus.pause & bus.unpause), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.clear = 1'b0;
    bus.mem_dq_in = '0;
    bus.data_available = 1'b0;
    bus.pix_ready = 1'b0;
    repeat (2) @(posedge ck143);
    #1;
    chk("rst_fill", 32'(bus.fill_level), 32'd0);
    chk("rst_valid", 32'(bus.pix_valid), 32'd0);
    chk("rst_data", 32'(bus.pix_data), 32'd0);
    chk("rst_pause", 32'(bus.pause), 32'd0);
    chk("rst_unpause", 32'(bus.unpause), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    reset = 1'b0;

    // first-word fall-through
    cycle(1'b1, 16'hA001, 1'b0, 1'b0);
    chk("t1_valid", 32'(bus.pix_valid), 32'd1);
    chk("t1_data", 32'(bus.pix_data), 32'hA001);
    cycle(1'b1, 16'hA002, 1'b0, 1'b0);
    chk("t1_fill", 32'(bus.fill_level), 32'd2);
    chk("t1_data2", 32'(bus.pix_data), 32'hA001);
    chk("t1_pause", 32'(bus.pause), 32'd0);

    // fill to high water, then a 2-word in-flight burst
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 16'hB000 + 16'(i), 1'b0, 1'b0);
      if (i < 9) chk("t2_no_pause", 32'(bus.pause), 32'd0);
    end
    chk("t2_fill12", 32'(bus.fill_level), 32'd12);
    chk("t2_pause", 32'(bus.pause), 32'd1);
    cycle(1'b1, 16'hB00A, 1'b0, 1'b0);
    chk("t2_pause_once", 32'(bus.pause), 32'd0);
    cycle(1'b1, 16'hB00B, 1'b0, 1'b0);
    chk("t2_fill14", 32'(bus.fill_level), 32'd14);
    chk("t2_ovf", 32'(bus.overflow), 32'd0);

    // drain from PAUSED: unpause exactly when fill reaches 4
    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      chk("t3_unpause", 32'(bus.unpause), 32'(q.size() == 4));
      chk("t3_pause", 32'(bus.pause), 32'd0);
    end
    chk("t3_n_pause", 32'(n_pause), 32'd1);
    chk("t3_n_unpause", 32'(n_unpause), 32'd1);

    // overflow: fill to 16, extra word dropped, full + pop still drops
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
    chk("t4_fill16", 32'(bus.fill_level), 32'd16);
    chk("t4_n_pause", 32'(n_pause), 32'd2);
    cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
    chk("t4_ovf", 32'(bus.overflow), 32'd1);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    chk("t4_ovf_sticky", 32'(bus.overflow), 32'd1);
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
    chk("t4_full_pop_fill", 32'(bus.fill_level), 32'd15);
    for (int i = 0; i < 15; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("t4_ovf_after_drain", 32'(bus.overflow), 32'd1);
    chk("t4_n_unpause", 32'(n_unpause), 32'd2);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    chk("t4_clr_ovf", 32'(bus.overflow), 32'd0);
    chk("t4_clr_unpause", 32'(bus.unpause), 32'd0);

    // steady state at 8 with simultaneous push and pop
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'hD000 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 16'hE000 + 16'(i), 1'b1, 1'b0);
      chk("t5_fill8", 32'(bus.fill_level), 32'd8);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("t5_n_pause", 32'(n_pause), 32'd2);

    // clear while PAUSED at 13, with a word on the clear edge
    for (int i = 0; i < 13; i++) cycle(1'b1, 16'h7000 + 16'(i), 1'b0, 1'b0);
    chk("t6_n_pause", 32'(n_pause), 32'd3);
    cycle(1'b1, 16'h1234, 1'b0, 1'b1);
    chk("t6_fill", 32'(bus.fill_level), 32'd0);
    chk("t6_valid", 32'(bus.pix_valid), 32'd0);
    chk("t6_ovf", 32'(bus.overflow), 32'd0);
    chk("t6_unpause", 32'(bus.unpause), 32'd1);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("t6_ready_idle", 32'(bus.fill_level), 32'd0);
    chk("t6_unpause_once", 32'(bus.unpause), 32'd0);
    cycle(1'b1, 16'hF00D, 1'b0, 1'b0);
    chk("t6_data", 32'(bus.pix_data), 32'hF00D);
    chk("t6_fill1", 32'(bus.fill_level), 32'd1);

    // asynchronous reset mid-operation
    cycle(1'b1, 16'h5001, 1'b0, 1'b0);
    cycle(1'b1, 16'h5002, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    chk("t7_async_fill", 32'(bus.fill_level), 32'd0);
    chk("t7_async_valid", 32'(bus.pix_valid), 32'd0);
    @(posedge ck143);
    #1;
    chk("t7_pause", 32'(bus.pause), 32'd0);
    chk("t7_unpause", 32'(bus.unpause), 32'd0);
    reset = 1'b0;
    cycle(1'b1, 16'h6001, 1'b0, 1'b0);
    chk("t7_after_data", 32'(bus.pix_data), 32'h6001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/sdram_pixel_fifo.md
Name: sdram_pixel_fifo

Overview:
- Downstream stage of the SDRAM read controller.
- Captures each 16-bit word returned on the SDRAM data bus while the controller flags data_available.
- Buffers the words in a synchronous FIFO and presents them to the pixel consumer over a valid/ready handshake.
- Generates pause/unpause pulses back to the controller so that read bursts stop before the FIFO overflows.

Parameters:
- DATA_W, 16, word width (matches the SDRAM dq width).
- ADDR_W, 4, FIFO address width; DEPTH = 2**ADDR_W = 16 entries.
- HIGH_WATER, 12, fill level at or above which pause is requested. Must be ≤ DEPTH-2 to absorb a 2-word in-flight burst.
- LOW_WATER, 4, fill level at or below which unpause is issued. Must be < HIGH_WATER.

Ports:
- ck143  in  1  system clock, same clock as the SDRAM and its controller; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush; same frame-restart strobe as the controller's clear.
- mem_dq_in  in  DATA_W  read data from the SDRAM dq bus (input side of the tristate).
- data_available  in  1  controller flag; each cycle it is high, mem_dq_in holds one valid word.
- pause  out  1  one-cycle pulse requesting the controller to stop issuing reads.
- unpause  out  1  one-cycle pulse releasing the controller.
- pix_data  out  DATA_W  FIFO head word.
- pix_valid  out  1  pix_data valid (FIFO not empty).
- pix_ready  in  1  consumer accepts pix_data this cycle when pix_valid=1.
- fill_level  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: a word was dropped because the FIFO was full.

Behaviour:
- Reset state (async assert, all outputs registered):
  - wr_ptr = rd_ptr = 0, fill_level = 0, pix_valid = 0, pix_data = 0.
  - pause = 0, unpause = 0, overflow = 0, flow FSM in RUNNING.
  - Deassertion is taken synchronously on the next ck143 edge.
- Write:
  - Edge with data_available=1 and fill_level<DEPTH: store mem_dq_in at wr_ptr; wr_ptr increments, wrapping DEPTH-1 → 0.
  - Edge with data_available=1 and fill_level==DEPTH: word is dropped, overflow set to 1. overflow holds until reset or clear.
- Read:
  - Pop occurs on an edge where pix_valid & pix_ready; rd_ptr increments with wrap.
  - pix_ready with pix_valid=0 has no effect.
- Latency (first-word fall-through, 1 cycle):
  - A word written into an empty FIFO at edge N gives pix_valid=1 and pix_data=that word from edge N+1.
  - pix_data always equals mem[rd_ptr] whenever pix_valid=1.
- Simultaneous push and pop: both occur and fill_level is unchanged. On full, a simultaneous pop still does not admit the incoming word, so overflow is set.
- fill_level: registered; updates on the same edge as the push/pop.
- Flow FSM, 2 states. Level comparisons use the next fill_level (the value being registered on that edge):
  - RUNNING: when next fill_level ≥ HIGH_WATER, go to PAUSED and drive pause=1 for exactly that cycle.
  - PAUSED: when next fill_level ≤ LOW_WATER, go to RUNNING and drive unpause=1 for exactly that cycle.
  - There is no repeat pulse while the FSM stays in the same state.
  - pause and unpause are never high together.
- clear (synchronous, takes priority over push/pop on the same edge):
  - Pointers and fill_level go to 0, pix_valid=0, overflow=0.
  - If the FSM was PAUSED, emit unpause=1 that cycle; FSM goes to RUNNING.
  - Any data_available on the clear edge is discarded.
- Reset mid-operation: all contents are lost immediately and no pulse is emitted.
- Parameter errors (HIGH_WATER ≥ DEPTH-1, or LOW_WATER ≥ HIGH_WATER) are a simulation-time $error.

Test Plan:
- Reset, then data_available high for 2 cycles with 0xA001, 0xA002, pix_ready=0 → pix_valid=1 one cycle after the first word, pix_data=0xA001, fill_level=2, no pause.
- Fill 12 words with pix_ready=0 → pause=1 for exactly one cycle on the edge fill_level becomes 12. A further 2-word burst → fill_level=14, overflow=0.
- From PAUSED at 14, pix_ready=1 continuously → data pops in order. unpause=1 for one cycle on the edge fill_level becomes 4; exactly one pause pulse total.
- Fill to 16, then one more word 0xDEAD → word dropped, overflow=1 stays set. Draining outputs the 16 original words only, never 0xDEAD.
- fill_level=8 with pix_ready=1 and data_available=1 every cycle for 10 cycles → fill_level stays 8 and the output order matches the input order.
- PAUSED at fill_level=13, assert clear for one cycle → fill_level=0, pix_valid=0, overflow=0, unpause=1 in the same cycle. The next write behaves as from reset.
